dfe_round_arbiter: RTL and testbench

- Shares one pipelined rounding datapath (round-half-away-from-zero, DIN_WIDTH to DOUT_WIDTH) among NUM_CH DFE channel requesters.
- Sits between per-channel accumulator/filter outputs and the narrow downstream bus.
- Each cycle it selects one valid requester by round-robin, rounds its sample, and emits the result tagged with the channel index.
- Replaces one rounding instance per channel with a single time-shared instance.

---
 rtl/dfe_round_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dfe_round_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dfe_round_arbiter.sv
// dfe_round_arbiter
//   Time-shares one two-stage rounding datapath among NUM_CH DFE channel
//   requesters. Each cycle a round-robin arbiter grants one valid channel.
//   The granted sample is rounded half-away-from-zero from DIN_WIDTH down to
//   DOUT_WIDTH bits. The result appears two cycles later, tagged with its
//   channel index.
//
// Ports
//   i_clk       clock for all logic
//   i_rst       synchronous reset, active-high
//   i_req_vld   [NUM_CH]            per-channel sample valid
//   i_req_data  [NUM_CH*DIN_WIDTH]  per-channel sample, channel k at [k*DIN_WIDTH +: DIN_WIDTH]
//   o_req_rdy   [NUM_CH]            one-hot combinational grant (0 during reset)
//   o_vld                           result valid
//   o_ch        [CH_W]              channel index of the result
//   o_data      [DOUT_WIDTH]        rounded result
//   o_ovf                           rounding add overflowed (saturated or wrapped)
module dfe_round_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DIN_WIDTH  = 39,
  parameter int DOUT_WIDTH = 17,
  parameter int SAT_EN     = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH-1:0]            i_req_vld,
  input  logic [NUM_CH*DIN_WIDTH-1:0]  i_req_data,
  output logic [NUM_CH-1:0]            o_req_rdy,
  output logic                         o_vld,
  output logic [CH_W-1:0]              o_ch,
  output logic [DOUT_WIDTH-1:0]        o_data,
  output logic                         o_ovf
);

  localparam int ROUND_WIDTH = DIN_WIDTH - DOUT_WIDTH;

  // Rounding constants. Positive samples add one half LSB. Negative samples
  // add one half LSB minus one, so an exact half rounds away from zero.
  localparam logic [DIN_WIDTH-1:0]  K_POS   = DIN_WIDTH'(1) << (ROUND_WIDTH - 1);
  localparam logic [DIN_WIDTH-1:0]  K_NEG   = K_POS - DIN_WIDTH'(1);
  localparam logic [DOUT_WIDTH-1:0] SAT_MAX = ~(DOUT_WIDTH'(1) << (DOUT_WIDTH - 1));
  localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
  logic [DIN_WIDTH-1:0]  s1_sum_q, s1_sum_d;
  logic                  s1_ovf_q, s1_ovf_d;
  logic                  out_vld_q, out_vld_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [DOUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_ovf_q, out_ovf_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  //   Requests at or above the pointer take priority. Without any such
  //   request, the search wraps to the lowest requester overall. This is
  //   the same as scanning p, p+1, ..., NUM_CH-1, 0, ...
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] hi_mask;
  logic [NUM_CH-1:0] req_hi;
  logic              hi_found;
  logic [CH_W-1:0]   hi_idx;
  logic [CH_W-1:0]   lo_idx;
  logic              grant_any;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign hi_mask[gi] = (CH_W'(gi) >= ptr_q);
  end

  assign req_hi = i_req_vld & hi_mask;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Scan downward so the lowest-index hit is the last one written.
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (req_hi[j]) begin
        hi_found = 1'b1;
        hi_idx   = CH_W'(j);
      end
      if (i_req_vld[j]) begin
        lo_idx = CH_W'(j);
      end
    end
    grant_any = !i_rst && (|i_req_vld);
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int j = 0; j < NUM_CH; j++) begin
      grant_vec[j] = grant_any && (grant_idx == CH_W'(j));
    end
  end

  assign o_req_rdy = grant_vec;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: select the granted sample and add the rounding constant
  // ---------------------------------------------------------------------------
  logic [DIN_WIDTH-1:0] data_sel;
  logic [DIN_WIDTH-1:0] sum_c;
  logic                 ovf_c;

  always_comb begin
    data_sel = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (grant_vec[j]) begin
        data_sel = i_req_data[j*DIN_WIDTH +: DIN_WIDTH];
      end
    end
    sum_c = data_sel + (data_sel[DIN_WIDTH-1] ? K_NEG : K_POS);
    // Only a positive sample can carry into the sign bit.
    ovf_c = !data_sel[DIN_WIDTH-1] && sum_c[DIN_WIDTH-1];
  end

  always_comb begin
    s1_vld_d = grant_any;
    s1_ch_d  = s1_ch_q;
    s1_sum_d = s1_sum_q;
    s1_ovf_d = s1_ovf_q;
    if (grant_any) begin
      s1_ch_d  = grant_idx;
      s1_sum_d = sum_c;
      s1_ovf_d = ovf_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: truncate, optionally saturate, register outputs
  //   o_data and o_ch hold their last values on idle cycles.
  // ---------------------------------------------------------------------------
  logic [DOUT_WIDTH-1:0] rounded;

  always_comb begin
    rounded = s1_sum_q[DIN_WIDTH-1:ROUND_WIDTH];
    if ((SAT_EN != 0) && s1_ovf_q) begin
      rounded = SAT_MAX;
    end
  end

  always_comb begin
    out_vld_d  = s1_vld_q;
    out_ovf_d  = s1_vld_q && s1_ovf_q;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;
    if (s1_vld_q) begin
      out_ch_d   = s1_ch_q;
      out_data_d = rounded;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_sum_q   <= '0;
      s1_ovf_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_ch_q   <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_vld_q   <= s1_vld_d;
      s1_ch_q    <= s1_ch_d;
      s1_sum_q   <= s1_sum_d;
      s1_ovf_q   <= s1_ovf_d;
      out_vld_q  <= out_vld_d;
      out_ch_q   <= out_ch_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign o_vld  = out_vld_q;
  assign o_ch   = out_ch_q;
  assign o_data = out_data_q;
  assign o_ovf  = out_ovf_q;

endmodule

// File: tb/tb_dfe_round_arbiter.sv
// Testbench for dfe_round_arbiter (NUM_CH=4, DIN_WIDTH=8, DOUT_WIDTH=4).
// A wrap instance (SAT_EN=0) and a saturating instance (SAT_EN=1) share the
// same stimulus. Expected results are queued when a grant is predicted and
// popped when they are due at the outputs.
module tb_dfe_round_arbiter;

  logic        clk;
  logic        i_rst;
  logic [3:0]  i_req_vld;
  logic [31:0] i_req_data;
  logic [3:0]  rdy0, rdy1;
  logic        vld0, vld1;
  logic [1:0]  ch0, ch1;
  logic [3:0]  data0, data1;
  logic        ovf0, ovf1;

  dfe_round_arbiter #(.NUM_CH(4), .CH_W(2), .DIN_WIDTH(8), .DOUT_WIDTH(4), .SAT_EN(0)) dut_wrap (
    .i_clk(clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .i_req_data(i_req_data),
    .o_req_rdy(rdy0), .o_vld(vld0), .o_ch(ch0), .o_data(data0), .o_ovf(ovf0)
  );

  dfe_round_arbiter #(.NUM_CH(4), .CH_W(2), .DIN_WIDTH(8), .DOUT_WIDTH(4), .SAT_EN(1)) dut_sat (
    .i_clk(clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .i_req_data(i_req_data),
    .o_req_rdy(rdy1), .o_vld(vld1), .o_ch(ch1), .o_data(data1), .o_ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [3:0] q_wrap;
    logic [3:0] q_sat;
    logic       ovf;
  } rnd_vec_t;

  typedef struct {
    int         due;
    logic [1:0] ch;
    logic [3:0] dw;
    logic [3:0] ds;
    logic       ovf;
  } sb_t;

  sb_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  int         obs_g = -1;
  logic [3:0] exp_w[4];
  logic [3:0] exp_s[4];
  logic       exp_o[4];
  logic [1:0] last_ch = '0;
  logic [3:0] last_w = '0;
  logic [3:0] last_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Reference rounding in plain integer arithmetic: magnitude rounded half-up, sign restored.
  task automatic model_round(input logic [7:0] d, output logic [3:0] w, output logic [3:0] s, output logic ov);
    int v;
    int r;
    v = int'($signed(d));
    if (v >= 0) r = (v + 8) / 16;
    else        r = -((-v + 8) / 16);
    ov = (r > 7);
    w  = r[3:0];
    s  = ov ? 4'h7 : r[3:0];
  endtask

  task automatic set_ch(input int c, input logic [7:0] d);
    i_req_data[c*8 +: 8] = d;
    model_round(d, exp_w[c], exp_s[c], exp_o[c]);
  endtask

  task automatic set_ch_exp(input int c, input rnd_vec_t v);
    i_req_data[c*8 +: 8] = v.din;
    exp_w[c] = v.q_wrap;
    exp_s[c] = v.q_sat;
    exp_o[c] = v.ovf;
  endtask

  // One clock cycle: predict and check the grant, queue the expected result,
  // advance the clock, then check the outputs against the scoreboard.
  task automatic tick();
    logic [3:0] exp_rdy;
    int         g;
    sb_t        e;
    logic       rst_now;
    #1;
    g = -1;
    exp_rdy = '0;
    if (!i_rst) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (g < 0 && i_req_vld[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("rdy_wrap", 32'(rdy0), 32'(exp_rdy));
    chk("rdy_sat", 32'(rdy1), 32'(exp_rdy));
    obs_g = -1;
    for (int i = 0; i < 4; i++) if (rdy0[i]) obs_g = i;
    if (g >= 0) begin
      e.due = cyc + 2;
      e.ch  = 2'(g);
      e.dw  = exp_w[g];
      e.ds  = exp_s[g];
      e.ovf = exp_o[g];
      sb.push_back(e);
    end
    rst_now = i_rst;
    @(posedge clk);
    cyc++;
    if (rst_now) begin
      m_ptr = 0;
      sb.delete();
    end else if (g >= 0) begin
      m_ptr = (g + 1) % 4;
    end
    #1;
    if (rst_now) begin
      chk("rst_vld", 32'({vld0, vld1}), 32'(0));
      chk("rst_ch", 32'({ch0, ch1}), 32'(0));
      chk("rst_data", 32'({data0, data1}), 32'(0));
      chk("rst_ovf", 32'({ovf0, ovf1}), 32'(0));
      last_ch = '0;
      last_w  = '0;
      last_s  = '0;
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("out_vld", 32'({vld0, vld1}), 32'(2'b11));
      chk("out_ch_wrap", 32'(ch0), 32'(e.ch));
      chk("out_ch_sat", 32'(ch1), 32'(e.ch));
      chk("out_data_wrap", 32'(data0), 32'(e.dw));
      chk("out_data_sat", 32'(data1), 32'(e.ds));
      chk("out_ovf", 32'({ovf0, ovf1}), 32'({e.ovf, e.ovf}));
      $display("txn cycle=%0d ch=%0d data_wrap=%0h data_sat=%0h ovf=%0b", cyc, ch0, data0, data1, ovf0);
      last_ch = e.ch;
      last_w  = e.dw;
      last_s  = e.ds;
    end else begin
      chk("idle_vld", 32'({vld0, vld1}), 32'(0));
      chk("idle_ovf", 32'({ovf0, ovf1}), 32'(0));
      chk("idle_ch_hold", 32'({ch0, ch1}), 32'({last_ch, last_ch}));
      chk("idle_data_hold", 32'({data0, data1}), 32'({last_w, last_s}));
    end
  endtask

  rnd_vec_t tbl[7];

  initial begin
    tbl[0] = '{din: 8'h18, q_wrap: 4'h2, q_sat: 4'h2, ovf: 1'b0};
    tbl[1] = '{din: 8'hE8, q_wrap: 4'hE, q_sat: 4'hE, ovf: 1'b0};
    tbl[2] = '{din: 8'hF8, q_wrap: 4'hF, q_sat: 4'hF, ovf: 1'b0};
    tbl[3] = '{din: 8'h07, q_wrap: 4'h0, q_sat: 4'h0, ovf: 1'b0};
    tbl[4] = '{din: 8'h08, q_wrap: 4'h1, q_sat: 4'h1, ovf: 1'b0};
    tbl[5] = '{din: 8'h7C, q_wrap: 4'h8, q_sat: 4'h7, ovf: 1'b1};
    tbl[6] = '{din: 8'h80, q_wrap: 4'h8, q_sat: 4'h8, ovf: 1'b0};

    i_rst = 1'b1;
    i_req_vld = '0;
    i_req_data = '0;
    for (int c = 0; c < 4; c++) set_ch(c, 8'h00);
    tick();
    tick();
    i_rst = 1'b0;

    // Rounding vectors on channel 0, each drained before the next.
    for (int t = 0; t < 7; t++) begin
      set_ch_exp(0, tbl[t]);
      i_req_vld = 4'b0001;
      tick();
      chk("rnd_grant", 32'(obs_g), 32'(0));
      i_req_vld = 4'b0000;
      tick();
      tick();
    end

    // Fairness: restart from channel 0, all channels requesting.
    i_rst = 1'b1;
    i_req_vld = 4'hF;
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("fair_order", 32'(obs_g), 32'(i % 4));
      if (i >= 2) chk("fair_vld_cont", 32'(vld0), 32'(1));
      if (obs_g >= 0) set_ch(obs_g, 8'($urandom_range(0, 255)));
    end
    i_req_vld = 4'h0;
    tick();
    tick();

    // Sparse: put the pointer at 2 with a lone ch1 grant, then ch1+ch3.
    i_req_vld = 4'b0010;
    tick();
    chk("sparse_prime", 32'(obs_g), 32'(1));
    i_req_vld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sparse_order", 32'(obs_g), 32'((i % 2 == 0) ? 3 : 1));
      if (obs_g >= 0) set_ch(obs_g, 8'($urandom_range(0, 255)));
    end

    // Idle: the pointer must survive five empty cycles (last grant was ch1).
    i_req_vld = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rdy", 32'(rdy0), 32'(0));
    end
    i_req_vld = 4'hF;
    tick();
    chk("idle_resume", 32'(obs_g), 32'(2));

    // Reset with samples in flight.
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_req_vld = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_vld", 32'(vld0), 32'(0));
    end
    i_req_vld = 4'hF;
    tick();
    chk("rst_restart", 32'(obs_g), 32'(0));
    i_req_vld = 4'h0;
    tick();
    tick();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      i_req_vld = 4'($urandom_range(0, 15));
      tick();
      if (obs_g >= 0) set_ch(obs_g, 8'($urandom_range(0, 255)));
    end
    i_req_vld = 4'h0;
    tick();
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
